// File: rtl/flash_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flash_reader_pkg
//  Description : Shared constants and state encoding for the serial-flash
//                burst reader (command 0x03, 24-bit address, mode 0).
//  Revision    : 1.0 - initial release
// ============================================================================
package flash_reader_pkg;

    localparam logic [7:0] READ_CMD      = 8'h03;
    localparam int         ADDRESS_WIDTH = 24;
    localparam int         BITS_HEADER   = 32;
    localparam int         COUNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMMAND = 3'd1,
        S_ADDRESS = 3'd2,
        S_DATA    = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/flash_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : flash_reader_if
//  Description : Request / byte-stream bundle between the flash reader and
//                its client (boot copy or cache fill).
//  Revision    : 1.0 - initial release
// ============================================================================
interface flash_reader_if;
    import flash_reader_pkg::*;

    logic                     start;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [COUNT_WIDTH-1:0]   count;
    logic                     busy;
    logic [7:0]               data_out;
    logic                     data_valid;
    logic                     data_ready;
    logic                     done;

    // Client side: issues requests and consumes bytes
    modport master (
        output start, address, count, data_ready,
        input  busy, data_out, data_valid, done
    );

    // Reader side
    modport slave (
        input  start, address, count, data_ready,
        output busy, data_out, data_valid, done
    );

endinterface
`default_nettype wire

// File: rtl/flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : flash_reader
//  Description : SPI mode-0 master that issues a 0x03 read with a 24-bit
//                address and streams back 'count' bytes through a
//                single-entry ready/valid buffer. The flash clock runs at
//                clk/2 and parks low whenever the buffer cannot take a byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_reader
    import flash_reader_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    flash_reader_if.slave bus,
    output logic          flash_clk,
    output logic          flash_mosi,
    input  logic          flash_miso,
    output logic          flash_cs_n
);

    // Finish keeps cs_n high for this many cycles before done may pulse
    localparam logic [1:0] c_FIN_HOLD = 2'd2;

    state_e                   state_q, state_d;
    logic                     sclk_q, sclk_d;
    logic                     cs_n_q, cs_n_d;
    logic [BITS_HEADER-1:0]   shift_q, shift_d;
    logic [4:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               in_q, in_d;
    logic                     pend_q, pend_d;
    logic [COUNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]               data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic [1:0]               fin_cnt_q, fin_cnt_d;

    logic                     w_accept;
    logic                     w_burst;
    logic                     w_shifting;
    logic                     w_rise;
    logic                     w_fall;
    logic                     w_take;
    logic                     w_byte_done;
    logic                     w_last_byte;
    logic                     w_fin_ready;
    logic [7:0]               w_new_byte;

    // start is only looked at while fully idle (busy also covers done cycle)
    assign w_accept    = (state_q == S_IDLE) && bus.start && !busy_q;
    assign w_burst     = w_accept && (bus.count != '0);
    assign w_shifting  = (state_q == S_COMMAND) || (state_q == S_ADDRESS) ||
                         (state_q == S_DATA);
    // A byte parked in in_q blocks the next rising edge, so no bit is lost
    assign w_rise      = w_shifting && !sclk_q && !pend_q;
    assign w_fall      = w_shifting && sclk_q;
    assign w_take      = valid_q && bus.data_ready;
    assign w_byte_done = (state_q == S_DATA) && w_fall && (bit_cnt_q == 5'd0);
    assign w_new_byte  = {in_q[6:0], flash_miso};
    assign w_last_byte = (byte_cnt_q == COUNT_WIDTH'(1));
    assign w_fin_ready = (fin_cnt_q == c_FIN_HOLD) && !pend_q &&
                         (!valid_q || bus.data_ready);

    assign flash_clk      = sclk_q;
    assign flash_mosi     = shift_q[BITS_HEADER-1];
    assign flash_cs_n     = cs_n_q;
    assign bus.busy       = busy_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.done       = done_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: phases advance when the bit counter wraps on a falling edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_burst) begin
                    state_d = S_COMMAND;
                end
            end
            S_COMMAND: begin
                if (w_fall && (bit_cnt_q == 5'd0)) begin
                    state_d = S_ADDRESS;
                end
            end
            S_ADDRESS: begin
                if (w_fall && (bit_cnt_q == 5'd0)) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_byte_done && w_last_byte) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (w_fin_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs and datapath next values: SPI shifting, byte buffer, handshake
    always_comb begin
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        in_d       = in_q;
        pend_d     = pend_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        fin_cnt_d  = fin_cnt_q;

        // Idle: busy follows acceptance; a zero-length request completes at once
        if (state_q == S_IDLE) begin
            busy_d = w_accept;
            if (w_accept && (bus.count == '0)) begin
                done_d = 1'b1;
            end
        end

        // First command bit appears on mosi together with the cs_n fall
        if (w_burst) begin
            cs_n_d     = 1'b0;
            shift_d    = {READ_CMD, bus.address};
            bit_cnt_d  = 5'd7;
            byte_cnt_d = bus.count;
        end

        if (w_rise) begin
            sclk_d = 1'b1;
        end

        // Falling edge: advance mosi, sample miso, step the bit counter
        if (w_fall) begin
            sclk_d = 1'b0;
            if (state_q == S_DATA) begin
                in_d = w_new_byte;
            end else begin
                shift_d = {shift_q[BITS_HEADER-2:0], 1'b0};
            end
            if (bit_cnt_q == 5'd0) begin
                bit_cnt_d = (state_q == S_COMMAND) ? 5'(ADDRESS_WIDTH - 1) : 5'd7;
            end else begin
                bit_cnt_d = bit_cnt_q - 5'd1;
            end
        end

        // Consumer takes the buffered byte; a parked byte moves up behind it
        if (w_take) begin
            if (pend_q) begin
                data_d = in_q;
                pend_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end

        // Completed byte goes to the output if it is free this cycle, else parks
        if (w_byte_done) begin
            byte_cnt_d = byte_cnt_q - COUNT_WIDTH'(1);
            if (!valid_q || bus.data_ready) begin
                data_d  = w_new_byte;
                valid_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        if (state_q == S_DATA) begin
            fin_cnt_d = 2'd0;
        end

        // Finish: cs_n high, wait out the hold time and the last hand-off
        if (state_q == S_FINISH) begin
            cs_n_d = 1'b1;
            if (fin_cnt_q != c_FIN_HOLD) begin
                fin_cnt_d = fin_cnt_q + 2'd1;
            end
            if (w_fin_ready) begin
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers; reset drops cs_n, parks the clock, discards bytes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= 5'd0;
            in_q       <= 8'h00;
            pend_q     <= 1'b0;
            byte_cnt_q <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            fin_cnt_q  <= 2'd0;
        end else begin
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            in_q       <= in_d;
            pend_q     <= pend_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            fin_cnt_q  <= fin_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_reader
//  Description : Self-checking bench for flash_reader with a behavioural
//                mode-0 flash and a random-backpressure consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_reader;
    import flash_reader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flash_clk;
    logic flash_mosi;
    logic flash_miso;
    logic flash_cs_n;

    flash_reader_if bus ();

    flash_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flash_clk  (flash_clk),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso),
        .flash_cs_n (flash_cs_n)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flash contents: every address mixes its three address bytes
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    // ---------------- behavioural flash (mode 0) ----------------
    logic [31:0] hdr_log[$];
    logic [31:0] hdr_sr = '0;
    int          hdr_bits = 0;
    int          out_bit = 0;

    initial begin
        logic [23:0] a;
        logic [7:0]  b;
        flash_miso = 1'b0;
        forever begin
            @(flash_clk or flash_cs_n);
            if (flash_cs_n) begin
                hdr_bits = 0;
                out_bit  = 0;
            end else if (flash_clk) begin
                if (hdr_bits < 32) begin
                    hdr_sr = {hdr_sr[30:0], flash_mosi};
                    hdr_bits++;
                    if (hdr_bits == 32) hdr_log.push_back(hdr_sr);
                end
            end else if (hdr_bits == 32) begin
                #1;
                a = hdr_sr[23:0] + 24'(out_bit / 8);
                b = mem_byte(a);
                flash_miso = b[7 - (out_bit % 8)];
                out_bit++;
            end
        end
    end

    // ---------------- consumer and protocol monitor ----------------
    logic [7:0]  rx_q[$];
    int unsigned vrise_q[$];
    int  rdy_mode = 0;
    bit  hold_arm = 0;
    int  hold_cnt = 0;
    int  rise_total = 0;
    int  rise_base = 0;
    int  done_total = 0;
    int  cs_fall_total = 0;
    int  cs_high_run = 0;
    bit  rst_guard = 0;

    initial begin
        logic       prev_fclk = 1'b0;
        logic       prev_cs = 1'b1;
        logic       prev_valid = 1'b0;
        logic       prev_acc = 1'b0;
        logic       prev_done = 1'b0;
        logic [7:0] prev_data = 8'h00;
        bus.data_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (flash_clk === 1'b1 && prev_fclk === 1'b0) begin
                rise_total++;
                check_eq("clk_rise_cs_low", flash_cs_n, 1'b0);
            end
            if (flash_cs_n === 1'b0 && prev_cs === 1'b1) begin
                cs_fall_total++;
                check_eq("cs_gap_ge2", cs_high_run >= 2, 1'b1);
            end
            cs_high_run = (flash_cs_n === 1'b1) ? cs_high_run + 1 : 0;
            if (bus.data_valid === 1'b1 && prev_valid !== 1'b1) vrise_q.push_back(cyc);
            if (prev_valid && !prev_acc && !rst_guard) begin
                check_eq("valid_held", bus.data_valid, 1'b1);
                check_eq("data_stable", bus.data_out, prev_data);
            end
            if (hold_arm && bus.data_valid) begin
                hold_arm = 0;
                hold_cnt = 100;
            end
            if (hold_cnt > 0) begin
                if (hold_cnt == 1) begin
                    check_eq("stall_rises", rise_total - rise_base, 32 + 16);
                    check_eq("stall_clk_low", flash_clk, 1'b0);
                    check_eq("stall_cs_low", flash_cs_n, 1'b0);
                end
                hold_cnt--;
                bus.data_ready = 1'b0;
            end else if (rdy_mode == 1) begin
                bus.data_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.data_ready = 1'b1;
            end
            if (bus.data_valid && bus.data_ready) rx_q.push_back(bus.data_out);
            if (bus.done === 1'b1) begin
                done_total++;
                check_eq("done_busy", bus.busy, 1'b1);
                check_eq("done_no_data", bus.data_valid, 1'b0);
                check_eq("done_cs_high3", cs_high_run >= 3, 1'b1);
            end
            if (prev_done) check_eq("busy_drop", bus.busy, 1'b0);
            prev_fclk  = flash_clk;
            prev_cs    = flash_cs_n;
            prev_valid = bus.data_valid;
            prev_acc   = bus.data_valid && bus.data_ready;
            prev_data  = bus.data_out;
            prev_done  = bus.done;
        end
    end

    // ---------------- one burst against the reference model ----------------
    // Called at a negedge; returns at the negedge after done.
    task automatic run_burst(input logic [23:0] addr, input logic [15:0] cnt,
                             input int mode, input int inject_at);
        int          db;
        int          fb;
        bit          ok;
        int unsigned start_cyc;
        logic [23:0] a;
        rdy_mode = mode;
        hold_arm = (mode == 2);
        rx_q.delete();
        hdr_log.delete();
        vrise_q.delete();
        rise_base = rise_total;
        db = done_total;
        fb = cs_fall_total;
        bus.start   = 1'b1;
        bus.address = addr;
        bus.count   = cnt;
        start_cyc   = cyc + 1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.address = 24'($urandom);
        bus.count   = 16'($urandom);
        if (cnt == 0) begin
            check_eq("zero_done", bus.done, 1'b1);
            check_eq("zero_busy", bus.busy, 1'b1);
            @(negedge clk);
            check_eq("zero_done_end", bus.done, 1'b0);
            check_eq("zero_busy_end", bus.busy, 1'b0);
            check_eq("zero_clk_edges", rise_total - rise_base, 0);
            check_eq("zero_cs_falls", cs_fall_total - fb, 0);
            return;
        end
        ok = 0;
        for (int i = 1; i < 4000; i++) begin
            bus.start = (i == inject_at);
            if (bus.done === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_eq("done_seen", ok, 1'b1);
        if (!ok) return;
        @(negedge clk);
        check_eq("done_count", done_total - db, 1);
        check_eq("cs_falls", cs_fall_total - fb, 1);
        check_eq("clk_rises", rise_total - rise_base, 32 + 8 * int'(cnt));
        check_eq("hdr_count", hdr_log.size(), 1);
        if (hdr_log.size() > 0) check_eq("hdr_mosi", hdr_log[0], {8'h03, addr});
        check_eq("first_valid_lat", (vrise_q.size() > 0) ? vrise_q[0] - start_cyc : 32'hFFFF_FFFF, 80);
        check_eq("rx_count", rx_q.size(), cnt);
        for (int i = 0; i < rx_q.size() && i < int'(cnt); i++) begin
            a = addr + 24'(i);
            check_eq($sformatf("rx_byte%0d", i), rx_q[i], mem_byte(a));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.start   = 1'b0;
        bus.address = '0;
        bus.count   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_data_out", bus.data_out, 8'h00);
        check_eq("rst_valid", bus.data_valid, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_fclk", flash_clk, 1'b0);
        check_eq("rst_mosi", flash_mosi, 1'b0);
        check_eq("rst_cs_n", flash_cs_n, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_burst(24'h000010, 16'd4, 0, -1);
        run_burst(24'($urandom), 16'd0, 0, -1);
        run_burst(24'($urandom), 16'd3, 2, -1);
        run_burst(24'($urandom), 16'd5, 0, 20);
        run_burst(24'($urandom), 16'd3, 1, 50);

        // Reset 40 cycles into the address phase
        rdy_mode    = 0;
        bus.start   = 1'b1;
        bus.address = 24'($urandom);
        bus.count   = 16'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (54) @(negedge clk);
        rst_guard = 1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_cs_n", flash_cs_n, 1'b1);
        check_eq("midrst_fclk", flash_clk, 1'b0);
        check_eq("midrst_valid", bus.data_valid, 1'b0);
        check_eq("midrst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_guard = 0;
        run_burst(24'($urandom), 16'd1, 0, -1);

        // Back-to-back bursts, including the address wrap
        run_burst(24'hFFFFFF, 16'd2, 0, -1);
        run_burst(24'($urandom), 16'd2, 1, -1);

        for (int n = 0; n < 8; n++) begin
            run_burst(24'($urandom), 16'($urandom_range(0, 6)), int'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 100)) : -1);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
